// File: rtl/data_bus_responder.sv
// Memory-side load/store responder with an internal word RAM and programmable wait states.
// Optional: define DBR_FAST_WRITE_EN to let valid stores and no-ops skip the wait states.
module data_bus_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_enable_i,
  input  logic [1:0]  rd_enable_i,
  input  logic        rd_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rd_data_o,
  output logic        err_o
);

  localparam int unsigned Words    = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        err_q;
  logic [31:0] rd_data_q;

  logic [31:0] addr_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_enable_q;
  logic [1:0]  rd_enable_q;
  logic        rd_unsigned_q;

  logic [31:0] mem_q [Words];

  // In IDLE the live inputs are classified so a zero-wait request can respond immediately.
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wen;
  logic [1:0]  cur_ren;
  logic        cur_uns;

  always_comb begin
    if (state_q == StIdle) begin
      cur_addr  = addr_i;
      cur_wdata = wr_data_i;
      cur_wen   = wr_enable_i;
      cur_ren   = rd_enable_i;
      cur_uns   = rd_unsigned_i;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wr_data_q;
      cur_wen   = wr_enable_q;
      cur_ren   = rd_enable_q;
      cur_uns   = rd_unsigned_q;
    end
  end

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  mask_ok;
  logic                  align_ok;
  logic                  is_store;
  logic                  is_load;
  logic                  is_noop;
  logic                  req_err;
  logic                  store_ok;

  always_comb begin
    offset   = cur_addr - BASE_ADDR;
    idx      = offset[DEPTH_LOG2+1:2];
    in_range = (cur_addr >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
    is_store = |cur_wen;
    is_load  = |cur_ren;
    is_noop  = !is_store && !is_load;

    case (cur_wen)
      4'b0001: mask_ok = (cur_addr[1:0] == 2'd0);
      4'b0010: mask_ok = (cur_addr[1:0] == 2'd1);
      4'b0100: mask_ok = (cur_addr[1:0] == 2'd2);
      4'b1000: mask_ok = (cur_addr[1:0] == 2'd3);
      4'b0011: mask_ok = (cur_addr[1:0] == 2'd0);
      4'b1100: mask_ok = (cur_addr[1:0] == 2'd2);
      4'b1111: mask_ok = (cur_addr[1:0] == 2'd0);
      default: mask_ok = 1'b0;
    endcase

    case (cur_ren)
      2'b10:   align_ok = !cur_addr[0];
      2'b11:   align_ok = (cur_addr[1:0] == 2'd0);
      default: align_ok = 1'b1;
    endcase

    req_err  = (is_store && is_load) ||
               (!is_noop && (!in_range || (is_store ? !mask_ok : !align_ok)));
    store_ok = is_store && !req_err;
  end

  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic [31:0] rsp_data;
  logic [31:0] wr_shift;

  always_comb begin
    rd_word  = mem_q[idx];
    rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
    case (cur_ren)
      2'b01:   rd_ext = cur_uns ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b10:   rd_ext = cur_uns ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      2'b11:   rd_ext = rd_shift;
      default: rd_ext = 32'd0;
    endcase
    rsp_data = (req_err || !is_load) ? 32'd0 : rd_ext;
    wr_shift = cur_wdata << {cur_addr[1:0], 3'b000};
  end

  logic skip_wait;
`ifdef DBR_FAST_WRITE_EN
  assign skip_wait = !is_load && !req_err;
`else
  assign skip_wait = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      ready_q       <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rd_data_q     <= 32'd0;
      err_q         <= 1'b0;
      addr_q        <= 32'd0;
      wr_data_q     <= 32'd0;
      wr_enable_q   <= 4'd0;
      rd_enable_q   <= 2'd0;
      rd_unsigned_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            addr_q        <= addr_i;
            wr_data_q     <= wr_data_i;
            wr_enable_q   <= wr_enable_i;
            rd_enable_q   <= rd_enable_i;
            rd_unsigned_q <= rd_unsigned_i;
            ready_q       <= 1'b0;
            if (WAIT_STATES == 0 || skip_wait) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rd_data_q   <= rsp_data;
              err_q       <= req_err;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitLoad;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rd_data_q   <= rsp_data;
            err_q       <= req_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM is not reset; a reset forces IDLE so a pending store never commits.
  always_ff @(posedge clock_i) begin
    if (state_q == StResp && store_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_wen[k]) begin
          mem_q[idx][8*k +: 8] <= wr_shift[8*k +: 8];
        end
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rd_data_o   = rd_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: directed requests push expectations, a monitor checks.
module tb_data_bus_responder;

`ifdef DBR_FAST_WRITE_EN
  localparam int TbWait = 3;
  localparam bit TbFast = 1'b1;
`else
  localparam int TbWait = 1;
  localparam bit TbFast = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_en = 4'd0;
  logic [1:0]  rd_en = 2'd0;
  logic        rd_uns = 1'b0;
  logic        rsp_valid;
  logic [31:0] rd_data;
  logic        err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          delta;
    int          acc;
  } exp_t;

  exp_t sb[$];

  data_bus_responder #(
    .DEPTH_LOG2 (10),
    .WAIT_STATES(TbWait),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .addr_i       (addr),
    .wr_data_i    (wr_data),
    .wr_enable_i  (wr_en),
    .rd_enable_i  (rd_en),
    .rd_unsigned_i(rd_uns),
    .rsp_valid_o  (rsp_valid),
    .rd_data_o    (rd_data),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", rd_data, e.data);
        check("rsp_err", {31'd0, err}, {31'd0, e.err});
        check("rsp_latency", cyc - e.acc, e.delta);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic [1:0] re, input logic un);
    addr      = a;
    wr_data   = wd;
    wr_en     = we;
    rd_en     = re;
    rd_uns    = un;
    req_valid = 1'b1;
  endtask

  // fastable: a valid store or no-op, which may bypass the wait states.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic [1:0] re, input logic un, input logic [31:0] ed,
                       input logic ee, input bit fastable);
    exp_t e;
    bit   ok;
    @(negedge clk);
    drive(a, wd, we, re, un);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 expected 1 within 20 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.data  = ed;
    e.err   = ee;
    e.delta = (TbFast && fastable) ? 0 : TbWait;
    e.acc   = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: got no response expected one within 40 cycles");
      sb.delete();
    end
  endtask

  initial begin
    int acc0;
    exp_t e;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    // Word round trip
    issue(32'h10, 32'hDEAD_BEEF, 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1);
    issue(32'h10, 32'd0, 4'b0000, 2'b11, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    // Byte store over a known word, then loads
    issue(32'h10, 32'h1122_3344, 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1);
    issue(32'h13, 32'h0000_0080, 4'b1000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1);
    issue(32'h13, 32'd0, 4'b0000, 2'b01, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b0);
    issue(32'h13, 32'd0, 4'b0000, 2'b01, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    issue(32'h10, 32'd0, 4'b0000, 2'b11, 1'b1, 32'h8022_3344, 1'b0, 1'b0);
    issue(32'h11, 32'd0, 4'b0000, 2'b01, 1'b1, 32'h0000_0033, 1'b0, 1'b0);
    issue(32'h12, 32'd0, 4'b0000, 2'b10, 1'b0, 32'hFFFF_8022, 1'b0, 1'b0);
    // Half loads
    issue(32'h20, 32'h8001_7FFF, 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1);
    issue(32'h22, 32'd0, 4'b0000, 2'b10, 1'b0, 32'hFFFF_8001, 1'b0, 1'b0);
    issue(32'h20, 32'd0, 4'b0000, 2'b10, 1'b1, 32'h0000_7FFF, 1'b0, 1'b0);
    // Errors
    issue(32'h21, 32'd0, 4'b0000, 2'b11, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(32'h0, 32'hCAFE_F00D, 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1);
    issue(32'h1000, 32'h5555_5555, 4'b1111, 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(32'h0, 32'd0, 4'b0000, 2'b11, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
    issue(32'h0, 32'hFF, 4'b0001, 2'b01, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(32'h12, 32'hFFFF, 4'b0011, 2'b00, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(32'h20, 32'h0, 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1);
    issue(32'h20, 32'd0, 4'b0000, 2'b11, 1'b0, 32'h8001_7FFF, 1'b0, 1'b0);

    // Request held high through WAIT: exactly one accept, ready low until after RESP
    @(negedge clk);
    acc0 = acc_cnt;
    drive(32'h10, 32'd0, 4'b0000, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    e.data  = 32'h8022_3344;
    e.err   = 1'b0;
    e.delta = TbWait;
    e.acc   = cyc;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_ready_low", {31'd0, req_ready}, 32'd0);
      if (rsp_valid) break;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("hold_accepts", acc_cnt - acc0, 32'd1);
    check("hold_queue_drained", sb.size(), 32'd0);
    sb.delete();

    // Reset in flight discards a store
    issue(32'h40, 32'h1234_5678, 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(32'h40, 32'hAAAA_AAAA, 4'b1111, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("midreset_ready", {31'd0, req_ready}, 32'd1);
    check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset_rd_data", rd_data, 32'd0);
    check("midreset_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (TbWait + 2) @(negedge clk);
    issue(32'h40, 32'd0, 4'b0000, 2'b11, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Memory-side responder for the core's load/store path.
- Accepts one request at a time over a valid/ready handshake.
- Request types: byte-enabled store (4-bit lane mask, as the store unit produces) or sized load (2-bit size code, as the load unit produces).
- Inserts a programmable number of wait states, then returns a one-cycle response with sign/zero-extended load data or an error flag.
- Sits between the core's ALU address / rs2 data path and a word-organised RAM it owns internally.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words).
- WAIT_STATES, 1, idle cycles inserted between accept and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.

Ports:
- clock_i  in  1  rising-edge clock
- reset_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept a request
- addr_i  in  32  byte address
- wr_data_i  in  32  store data, least-significant-byte aligned (unshifted rs2)
- wr_enable_i  in  4  byte-lane write mask, already positioned by addr_i[1:0]
- rd_enable_i  in  2  load size: 00 none, 01 byte, 10 half, 11 word
- rd_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend
- rsp_valid_o  out  1  one-cycle response strobe
- rd_data_o  out  32  extended load data; 0 for stores and errors
- err_o  out  1  error qualifier, valid with rsp_valid_o

Behaviour:
- Reset (reset_i low, asynchronous):
  - State goes to IDLE.
  - Outputs: req_ready_o=1, rsp_valid_o=0, rd_data_o=0, err_o=0.
  - Wait counter cleared.
  - RAM contents are not cleared.
  - Reset mid-operation discards the latched request; no write occurs.
- States:
  - IDLE: req_ready_o=1. On req_valid_i=1, latch addr, wr_data, wr_enable, rd_enable, rd_unsigned. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: req_ready_o=0. Counter loads WAIT_STATES-1 on entry and decrements each cycle. At 0, go to RESP.
  - RESP: req_ready_o=0. RAM read/write performed this cycle; rsp_valid_o=1 for exactly this cycle. Next state is IDLE.
- Latency: accept at edge N, rsp_valid_o high in cycle N+1+WAIT_STATES. A new request can be accepted one cycle after RESP.
- Request classification, in priority order:
  - wr_enable_i!=0 and rd_enable_i!=0 → error.
  - Both zero → no-op: response with err_o=0, rd_data_o=0.
  - Word index = (addr-BASE_ADDR)>>2. Index >= 2^DEPTH_LOG2, or addr<BASE_ADDR → error.
  - Misaligned → error:
    - half load with addr[0]=1;
    - word load with addr[1:0]!=0;
    - store mask not in {0001,0010,0100,1000,0011,1100,1111}, or inconsistent with addr[1:0].
- Error response: err_o=1, rd_data_o=0, RAM unmodified.
- Store: wr_data_i shifted left by 8*addr[1:0]. Each set lane k writes byte k of the addressed word; other bytes unchanged.
- Load:
  - Word read, then shifted right by 8*addr[1:0].
  - Low 8/16/32 bits extended per rd_unsigned_i. Word loads ignore rd_unsigned_i.
- rd_data_o and err_o hold their RESP values until the next RESP or reset. They are only meaningful while rsp_valid_o=1.
- req_valid_i while not ready is ignored. The requester must hold the request until accepted.
- Address arithmetic is modulo 2^32; wrap below BASE_ADDR is out of range.

Optional Feature:
- Macro: DBR_FAST_WRITE_EN.
- Defined: valid stores and no-ops skip WAIT and go IDLE→RESP directly (latency 1 cycle). Loads and errored requests still wait.
- Undefined: all requests incur WAIT_STATES.

Test Plan:
- Word round trip, WAIT_STATES=1: store 32'hDEADBEEF to 0x10 with mask 1111 → rsp_valid_o at accept+2, err_o=0. Word load from 0x10 → rd_data_o=32'hDEADBEEF, err_o=0.
- Byte store then loads: store 0x80 to 0x13 with mask 1000 over word 0x11223344. Signed byte load from 0x13 → 32'hFFFFFF80. Unsigned byte load → 32'h00000080. Word load → 32'h80223344.
- Half load extension: word 0x8001_7FFF at 0x20. Signed half at 0x22 → 32'hFFFF8001. Unsigned half at 0x20 → 32'h00007FFF.
- Errors:
  - Word load at 0x21 → err_o=1, rd_data_o=0.
  - Store to word index 1024 (DEPTH_LOG2=10) → err_o=1, and a subsequent read of word 0 is unchanged.
  - wr_enable=0001 with rd_enable=01 → err_o=1.
- Handshake/reset:
  - Hold req_valid_i through WAIT → only one accept; req_ready_o=0 until after RESP.
  - Assert reset_i low during WAIT of a store → rsp_valid_o never pulses, outputs return to reset values immediately, and the target word is unchanged.
- With DBR_FAST_WRITE_EN and WAIT_STATES=3:
  - Store → rsp_valid_o at accept+1.
  - Load → rsp_valid_o at accept+4.
